// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential shifter: operation codes and FSM states.
package seq_shifter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational k-position shift of a WIDTH-bit value for one op.
// Rotate-right exists only when SEQ_SHIFTER_ROT_EN is defined; otherwise op=11 acts as SRL.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   k,
  output logic [WIDTH-1:0] res
);

`ifdef SEQ_SHIFTER_ROT_EN
  logic [2*WIDTH-1:0] dbl;
  assign dbl = {val, val} >> k;
`endif

  always_comb begin
    res = val;
    case (op_e'(op))
      OP_SLL: res = val << k;
      OP_SRL: res = val >> k;
      OP_SRA: res = $unsigned($signed(val) >>> k);
`ifdef SEQ_SHIFTER_ROT_EN
      OP_ROR: res = dbl[WIDTH-1:0];
`else
      OP_ROR: res = val >> k;
`endif
      default: res = val;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: up to STEP positions per cycle, IDLE -> SHIFT -> DONE -> IDLE.
// Optional rotate-right on op=11 via macro SEQ_SHIFTER_ROT_EN.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  state_e           state, state_n;
  logic [WIDTH-1:0] work, work_n, step_res;
  logic [SHW-1:0]   remain, remain_n, k;
  logic [1:0]       op_q, op_n;
  logic             load_out;
  logic [31:0]      rem_ext;

  // remain < WIDTH always, so the STEP branch is only taken when STEP fits in SHW bits
  assign rem_ext = 32'(remain);
  assign k = (rem_ext < 32'(STEP)) ? remain : SHW'(STEP);

  shift_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
    .val (work),
    .op  (op_q),
    .k   (k),
    .res (step_res)
  );

  always_comb begin
    state_n  = state;
    work_n   = work;
    remain_n = remain;
    op_n     = op_q;
    load_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          work_n   = data_in;
          remain_n = shamt;
          op_n     = op;
          if (shamt == '0) begin
            state_n  = ST_DONE;
            load_out = 1'b1;
          end else begin
            state_n = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_n   = step_res;
        remain_n = remain - k;
        if (remain == k) begin
          state_n  = ST_DONE;
          load_out = 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      work     <= '0;
      remain   <= '0;
      op_q     <= '0;
      data_out <= '0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      remain <= remain_n;
      op_q   <= op_n;
      if (load_out) data_out <= work_n;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench: STEP=1 and STEP=4 instances, directed table, random ops, corner sequences.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  int          sel = 0;

  logic        start1, start4;
  logic        busy1, done1, busy4, done4;
  logic [31:0] dout1, dout4;
  logic        m_busy, m_done;
  logic [31:0] m_data;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign start1 = start & (sel == 0);
  assign start4 = start & (sel == 1);
  assign m_busy = (sel == 0) ? busy1 : busy4;
  assign m_done = (sel == 0) ? done1 : done4;
  assign m_data = (sel == 0) ? dout1 : dout4;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy1), .done(done1), .data_out(dout1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy4), .done(done4), .data_out(dout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int sh);
    logic signed [63:0] x;
    case (o)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: begin
        x = {{32{d[31]}}, d};
        x = x >>> sh;
        return x[31:0];
      end
      default: begin
`ifdef SEQ_SHIFTER_ROT_EN
        if (sh == 0) return d;
        return (d >> sh) | (d << (32 - sh));
`else
        return d >> sh;
`endif
      end
    endcase
  endfunction

  function automatic int latency(input int sh, input int step);
    return (sh + step - 1) / step + 1;
  endfunction

  // Caller is in an IDLE cycle; that cycle becomes cycle 0.
  task automatic run(input int s, input logic [1:0] o, input logic [31:0] d, input logic [4:0] sh,
                     input logic [31:0] exp_d, input int exp_lat, input string nm);
    int cyc;
    bit busy_ok;
    bit got;
    sel = s; op = o; data_in = d; shamt = sh; start = 1'b1;
    cyc = 0; busy_ok = 1'b1; got = 1'b0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      start = 1'b0;
      if (!m_busy) busy_ok = 1'b0;
      if (m_done) got = 1'b1;
    end
    check({nm, " latency"}, got ? cyc : -1, exp_lat);
    check({nm, " data"}, m_data, exp_d);
    check({nm, " busy"}, busy_ok, 1'b1);
    tick();
    check({nm, " idle after"}, {m_busy, m_done}, 2'b00);
  endtask

  typedef struct {
    int          s;
    logic [1:0]  o;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] exp_d;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 2'b01, 32'h8000_0001, 5'd1,  32'h4000_0000, 2, "srl1"};
    vecs[1] = '{0, 2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 5, "sra4"};
    vecs[2] = '{0, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, "sll0"};
    vecs[3] = '{1, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 9, "step4_srl31"};
`ifdef SEQ_SHIFTER_ROT_EN
    vecs[4] = '{0, 2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2, "op11"};
`else
    vecs[4] = '{0, 2'b11, 32'h0000_0001, 5'd1,  32'h0000_0000, 2, "op11"};
`endif
    vecs[5] = '{1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, "step4_sra31"};

    tick(); tick();
    check("reset busy1", busy1, 1'b0);
    check("reset done1", done1, 1'b0);
    check("reset dout1", dout1, 32'h0);
    check("reset dout4", dout4, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run(vecs[i].s, vecs[i].o, vecs[i].d, vecs[i].sh, vecs[i].exp_d, vecs[i].exp_lat, vecs[i].nm);

    for (int i = 0; i < 30; i++) begin
      int s; logic [1:0] o; logic [31:0] d; int sh;
      s  = $urandom_range(0, 1);
      o  = 2'($urandom_range(0, 3));
      d  = $urandom;
      sh = $urandom_range(0, 31);
      run(s, o, d, 5'(sh), model(o, d, sh), latency(sh, (s == 0) ? 1 : 4), "rand");
    end

    // start during SHIFT must be ignored
    begin
      int cyc; bit got;
      sel = 0; op = 2'b00; data_in = 32'h0000_00FF; shamt = 5'd5; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      start = 1'b1; op = 2'b01; data_in = 32'hDEAD_BEEF; shamt = 5'd1;
      tick(); start = 1'b0;
      cyc = 3; got = 1'b0;
      while (!got && cyc < 100) begin
        if (m_done) got = 1'b1;
        else begin tick(); cyc++; end
      end
      check("interfere latency", got ? cyc : -1, 6);
      check("interfere data", m_data, 32'h0000_1FE0);
      tick();
      check("interfere idle", {m_busy, m_done}, 2'b00);
    end

    // reset mid-shift aborts with no done pulse
    begin
      bit saw;
      sel = 0; op = 2'b00; data_in = 32'h0000_0003; shamt = 5'd5; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst abort busy", busy1, 1'b0);
      check("rst abort done", done1, 1'b0);
      check("rst abort dout", dout1, 32'h0);
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done1 || busy1) saw = 1'b1;
      end
      check("rst no late done", saw, 1'b0);
    end

    // rst wins over start in the same cycle
    begin
      bit saw;
      sel = 0; op = 2'b01; data_in = 32'h0000_0100; shamt = 5'd0;
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      check("rst prio busy", busy1, 1'b0);
      saw = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (done1 || busy1) saw = 1'b1;
      end
      check("rst prio no done", saw, 1'b0);
    end

    run(0, 2'b10, 32'h7000_0000, 5'd3, 32'h0E00_0000, 4, "post_rst_sra");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
